mac_sched: RTL and testbench
============================

// Module: mac_sched
// PURPOSE
// - Job-level sequencer for one mac instance: accepts a row-grouped (row, value0, value1) stream, issues it to the mac,
//   drives mac done/flush, and buffers mac results in a FIFO with valid/ready output.
// - mac has no backpressure, so issue is credit-limited: a new row is issued only if a FIFO slot is reserved for it.
// PARAMETERS
// - ROW_W      10     row index width (matches mac row port)
// - DATA_W     64     operand/result width
// - FIFO_DEPTH 16     result FIFO entries (power of 2, 4..64) = row credits
// - CNT_W      16     rows_issued / rows_returned counter width
// - TIMEOUT    1024   max DRAIN cycles before err_timeout
// PORTS
// - clk           in   1       clock
// - reset_n       in   1       asynchronous, active-low reset
// - start         in   1       pulse in IDLE: begin job; ignored elsewhere
// - busy          out  1       high in RUN/DRAIN
// - job_done      out  1       one-cycle pulse on DRAIN->IDLE
// - in_last       in   1       qualifies final input entry of job
// - in_valid/in_ready in/out 1 input handshake; transfer when both high
// - in_row        in   ROW_W   row index; entries of one row contiguous
// - in_value0/1   in   DATA_W  multiplicand operands
// - mac_wr        out  1       issue strobe to mac
// - mac_row       out  ROW_W   registered row to mac
// - mac_value0/1  out  DATA_W  registered operands to mac
// - mac_done      out  1       mac done input (starts flush counter)
// - mac_push      in   1       mac result valid
// - mac_dout      in   DATA_W  mac result
// - out_valid/out_ready out/in 1 result handshake; out_data DATA_W FIFO head
// - rows_issued   out  CNT_W   distinct rows issued this job
// - rows_returned out  CNT_W   mac_push count this job
// - err_overflow  out  1       sticky: mac_push with FIFO full (result dropped)
// - err_timeout   out  1       sticky: DRAIN ended by TIMEOUT
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; FIFO empty; counters 0; errors cleared. Errors also clear on accepted start.
// - FSM IDLE -start-> RUN (counters cleared, first_entry=1).
//   RUN -accepted entry with in_last-> DRAIN. DRAIN: mac_done=1 continuously.
//   DRAIN -> IDLE when rows_returned==rows_issued and 1 cycle has passed since entry, or after TIMEOUT cycles
//   (sets err_timeout). job_done pulses on that transition; mac_done drops same edge.
// - New row: first_entry, or in_row != last issued row. Same-row entries need no credit.
// - Credits: reserved = rows_issued - rows_popped (rows_popped = out handshakes this job, plus FIFO occupancy
//   carried from prior job). in_ready = RUN && in_valid-independent && (!new_row || reserved < FIFO_DEPTH).
//   in_ready is combinational from in_row; must not depend on in_valid.
// - Issue latency 1: accepted entry at edge N appears on mac_* with mac_wr=1 during cycle N+1; mac_wr=0 otherwise.
//   rows_issued increments at the same edge as a new-row accept.
// - mac_push writes FIFO; if FIFO full, drop, set err_overflow. Push and pop same cycle with FIFO full: pop frees
//   slot, push accepted. rows_returned counts every mac_push (including dropped); saturates at all-ones.
// - out_valid = FIFO non-empty; out_data stable while out_valid && !out_ready. FIFO not flushed between jobs.
// - start while busy ignored. Reset mid-job: immediate IDLE, FIFO emptied, mac_wr/mac_done low asynchronously.
// - Zero-entry jobs unsupported: job always has >=1 entry ending with in_last.
// - rows_issued wraps modulo 2^CNT_W; credit arithmetic uses CNT_W-bit modular difference.
// STRUCTURE
// - Package mac_sched_pkg: state enum {IDLE,RUN,DRAIN}, default widths ROW_W/DATA_W.
// - One sub-module: mac_result_fifo (sync FIFO, DEPTH x DATA_W, full/empty/count, async active-low reset).
// - Top holds FSM, issue registers, credit logic, counters, timeout counter.
// TESTING
// - Rows 3,3,5,7 (4 entries, in_last on 4th), mac model returns 3 pushes -> rows_issued=3, 3 outputs, job_done once.
// - FIFO_DEPTH=4, out_ready=0, 6 distinct rows -> in_ready low at 5th row; same-row entries of row 4 still accepted.
// - Push on full FIFO (model forced) -> err_overflow=1, out count unchanged, cleared by next start.
// - Model withholds last result -> DRAIN lasts exactly TIMEOUT=1024 cycles, err_timeout=1, job_done pulse.
// - Assert reset_n low mid-RUN with mac_wr high -> mac_wr, mac_done, busy, out_valid 0 immediately; start works next.
// - Simultaneous push/pop with FIFO full for 10 cycles -> no overflow, order preserved (values 1..N checked).

Source files
------------

// File: rtl/mac_sched_pkg.sv
// rtl/mac_sched_pkg.sv - shared types and default widths for the mac job sequencer
package mac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_ROW_W  = 10;
    localparam int DEF_DATA_W = 64;

endpackage

// File: rtl/mac_result_fifo.sv
// rtl/mac_result_fifo.sv - synchronous result FIFO with full/empty/count flags
module mac_result_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_sched.sv
// rtl/mac_sched.sv - credit-limited job sequencer feeding one mac and buffering its results
module mac_sched
    import mac_sched_pkg::*;
#(
    parameter int ROW_W      = DEF_ROW_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              job_done,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROW_W-1:0]  in_row,
    input  logic [DATA_W-1:0] in_value0,
    input  logic [DATA_W-1:0] in_value1,
    output logic              mac_wr,
    output logic [ROW_W-1:0]  mac_row,
    output logic [DATA_W-1:0] mac_value0,
    output logic [DATA_W-1:0] mac_value1,
    output logic              mac_done,
    input  logic              mac_push,
    input  logic [DATA_W-1:0] mac_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  rows_issued,
    output logic [CNT_W-1:0]  rows_returned,
    output logic              err_overflow,
    output logic              err_timeout
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int FC_W = $clog2(FIFO_DEPTH + 1);

    state_t            state;
    logic              first_entry;
    logic [ROW_W-1:0]  last_row;
    logic [CNT_W-1:0]  rows_popped;
    logic [CNT_W-1:0]  reserved;
    logic [TO_W-1:0]   drain_cnt;
    logic              new_row;
    logic              accept;
    logic              pop_fire;
    logic              start_fire;
    logic              drain_match;
    logic              drain_expire;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FC_W-1:0]   fifo_count;

    mac_result_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (mac_push),
        .push_data (mac_dout),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid  = !fifo_empty;
    assign pop_fire   = out_valid && out_ready;
    assign start_fire = (state == IDLE) && start;

    // Slots spoken for: rows issued and not yet drained out of the FIFO, modulo counter width.
    assign reserved = rows_issued - rows_popped;
    assign new_row  = first_entry || (in_row != last_row);
    // Deliberately independent of in_valid so the upstream can probe credit before committing.
    assign in_ready = (state == RUN) && (!new_row || (reserved < CNT_W'(FIFO_DEPTH)));
    assign accept   = in_valid && in_ready;

    assign drain_match  = (drain_cnt != '0) && (rows_returned == rows_issued);
    assign drain_expire = (drain_cnt == TO_W'(TIMEOUT - 1));

    // Job FSM with registered busy/mac_done/job_done, credit and drain bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            mac_done    <= 1'b0;
            first_entry <= 1'b0;
            last_row    <= '0;
            rows_issued <= '0;
            rows_popped <= '0;
            drain_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            job_done <= 1'b0;
            if (state != IDLE && pop_fire) begin
                rows_popped <= rows_popped + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        first_entry <= 1'b1;
                        rows_issued <= '0;
                        // Results left over from the previous job still occupy slots.
                        rows_popped <= CNT_W'(pop_fire) - CNT_W'(fifo_count);
                        err_timeout <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        first_entry <= 1'b0;
                        last_row    <= in_row;
                        if (new_row) begin
                            rows_issued <= rows_issued + CNT_W'(1);
                        end
                        if (in_last) begin
                            state     <= DRAIN;
                            mac_done  <= 1'b1;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + TO_W'(1);
                    if (drain_match || drain_expire) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        mac_done <= 1'b0;
                        job_done <= 1'b1;
                        if (!drain_match) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Issue registers: one-cycle strobe carrying the accepted entry to the mac.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_wr     <= 1'b0;
            mac_row    <= '0;
            mac_value0 <= '0;
            mac_value1 <= '0;
        end else begin
            mac_wr <= accept;
            if (accept) begin
                mac_row    <= in_row;
                mac_value0 <= in_value0;
                mac_value1 <= in_value1;
            end
        end
    end

    // Result accounting: saturating return count and sticky overflow on dropped pushes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rows_returned <= '0;
            err_overflow  <= 1'b0;
        end else if (start_fire) begin
            rows_returned <= '0;
            err_overflow  <= 1'b0;
        end else begin
            if (mac_push && (rows_returned != '1)) begin
                rows_returned <= rows_returned + CNT_W'(1);
            end
            if (mac_push && fifo_full && !pop_fire) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_sched.sv
// tb/tb_mac_sched.sv - scoreboard bench for the mac job sequencer
module tb_mac_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        job_done;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_row;
    logic [63:0] in_value0;
    logic [63:0] in_value1;
    logic        mac_wr;
    logic [9:0]  mac_row;
    logic [63:0] mac_value0;
    logic [63:0] mac_value1;
    logic        mac_done;
    logic        mac_push;
    logic [63:0] mac_dout;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [15:0] rows_issued;
    logic [15:0] rows_returned;
    logic        err_overflow;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    int jd_cnt = 0;
    int drain_cyc = 0;
    logic [63:0] exp_q[$];
    logic [9:0]  exp_mac[$];
    logic [9:0]  mon_row;

    always #5 clk = ~clk;

    mac_sched #(
        .ROW_W      (10),
        .DATA_W     (64),
        .FIFO_DEPTH (4),
        .CNT_W      (16),
        .TIMEOUT    (1024)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .busy          (busy),
        .job_done      (job_done),
        .in_last       (in_last),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_row        (in_row),
        .in_value0     (in_value0),
        .in_value1     (in_value1),
        .mac_wr        (mac_wr),
        .mac_row       (mac_row),
        .mac_value0    (mac_value0),
        .mac_value1    (mac_value1),
        .mac_done      (mac_done),
        .mac_push      (mac_push),
        .mac_dout      (mac_dout),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .rows_issued   (rows_issued),
        .rows_returned (rows_returned),
        .err_overflow  (err_overflow),
        .err_timeout   (err_timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: result and issue scoreboards, pulse and drain-cycle counters.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got %0h expected nothing", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
        if (reset_n && mac_wr) begin
            if (exp_mac.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mac_unexpected: got row %0d expected nothing", mac_row);
            end else begin
                mon_row = exp_mac.pop_front();
                chk("mac_row", 64'(mac_row), 64'(mon_row));
                chk("mac_value0", mac_value0, 64'(mon_row) + 64'd100);
            end
        end
        if (job_done) jd_cnt++;
        if (mac_done) drain_cyc++;
    end

    task automatic start_job();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [9:0] row, input logic last);
        int n = 0;
        in_valid  = 1'b1;
        in_row    = row;
        in_value0 = 64'(row) + 64'd100;
        in_value1 = 64'(row) + 64'd200;
        in_last   = last;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_wait row %0d: in_ready got 0 expected 1", row);
        end else begin
            exp_mac.push_back(row);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_res(input logic [63:0] d, input logic expect_out);
        mac_push = 1'b1;
        mac_dout = d;
        if (expect_out) exp_q.push_back(d);
        @(posedge clk); #1;
        mac_push = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy got 1 expected 0");
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time got limit expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        in_value0 = '0;
        in_value1 = '0;
        mac_push  = 1'b0;
        mac_dout  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_mac_wr", 64'(mac_wr), 0);
        chk("rst_mac_done", 64'(mac_done), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_rows_issued", 64'(rows_issued), 0);
        chk("rst_errs", 64'({err_overflow, err_timeout}), 0);
        @(posedge clk); #1;

        // Basic job: rows 3,3,5,7 give three distinct rows and three results.
        out_ready = 1'b1;
        start_job();
        @(negedge clk);
        chk("t1_busy", 64'(busy), 1);
        @(posedge clk); #1;
        send(10'd3, 1'b0);
        send(10'd3, 1'b0);
        send(10'd5, 1'b0);
        send(10'd7, 1'b1);
        @(negedge clk);
        chk("t1_rows_issued", 64'(rows_issued), 3);
        chk("t1_mac_done", 64'(mac_done), 1);
        @(posedge clk); #1;
        push_res(64'h11, 1'b1);
        push_res(64'h22, 1'b1);
        push_res(64'h33, 1'b1);
        wait_idle();
        chk("t1_job_done", 64'(jd_cnt), 1);
        chk("t1_rows_returned", 64'(rows_returned), 3);
        chk("t1_outs_drained", 64'(exp_q.size()), 0);

        // Credit limit: four distinct rows fill the FIFO credits.
        out_ready = 1'b0;
        start_job();
        send(10'd1, 1'b0);
        send(10'd2, 1'b0);
        send(10'd3, 1'b0);
        send(10'd4, 1'b0);
        send(10'd4, 1'b0);
        in_valid  = 1'b1;
        in_row    = 10'd5;
        in_value0 = 64'd105;
        @(negedge clk);
        chk("t2_ready_row5", 64'(in_ready), 0);
        chk("t2_rows_issued", 64'(rows_issued), 4);
        in_valid = 1'b0;
        #1;
        chk("t2_ready_novalid", 64'(in_ready), 0);
        in_row = 10'd4;
        #1;
        chk("t2_ready_same_row", 64'(in_ready), 1);
        @(posedge clk); #1;
        push_res(64'hA1, 1'b1);
        push_res(64'hA2, 1'b1);
        push_res(64'hA3, 1'b1);
        push_res(64'hA4, 1'b1);
        out_ready = 1'b1;
        send(10'd5, 1'b0);
        send(10'd6, 1'b1);
        push_res(64'hA5, 1'b1);
        push_res(64'hA6, 1'b1);
        wait_idle();
        chk("t2_rows_issued_end", 64'(rows_issued), 6);
        chk("t2_rows_returned", 64'(rows_returned), 6);
        chk("t2_job_done", 64'(jd_cnt), 2);

        // Overflow: extra push into a full FIFO is dropped and flagged.
        out_ready = 1'b0;
        start_job();
        send(10'd10, 1'b0);
        send(10'd11, 1'b0);
        send(10'd12, 1'b0);
        send(10'd13, 1'b1);
        push_res(64'hB1, 1'b1);
        push_res(64'hB2, 1'b1);
        push_res(64'hB3, 1'b1);
        push_res(64'hB4, 1'b1);
        wait_idle();
        chk("t3_no_overflow_yet", 64'(err_overflow), 0);
        push_res(64'hB5, 1'b0);
        @(negedge clk);
        chk("t3_err_overflow", 64'(err_overflow), 1);
        chk("t3_rows_returned", 64'(rows_returned), 5);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t3_out_count", 64'(exp_q.size()), 0);
        chk("t3_out_valid", 64'(out_valid), 0);
        chk("t3_job_done", 64'(jd_cnt), 3);

        // Timeout: one result withheld, DRAIN must last exactly 1024 cycles.
        start_job();
        @(negedge clk);
        chk("t4_overflow_cleared", 64'(err_overflow), 0);
        @(posedge clk); #1;
        drain_cyc = 0;
        send(10'd20, 1'b0);
        send(10'd21, 1'b1);
        push_res(64'hC1, 1'b1);
        wait_idle();
        chk("t4_drain_cycles", 64'(drain_cyc), 1024);
        chk("t4_err_timeout", 64'(err_timeout), 1);
        chk("t4_job_done", 64'(jd_cnt), 4);

        // Reset mid-RUN with an issue strobe in flight.
        out_ready = 1'b0;
        start_job();
        push_res(64'h99, 1'b0);
        @(negedge clk);
        chk("t5_out_valid_pre", 64'(out_valid), 1);
        in_valid  = 1'b1;
        in_row    = 10'd30;
        in_value0 = 64'd130;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5_mac_wr_pre", 64'(mac_wr), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_mac_wr", 64'(mac_wr), 0);
        chk("t5_mac_done", 64'(mac_done), 0);
        chk("t5_busy", 64'(busy), 0);
        chk("t5_out_valid", 64'(out_valid), 0);
        chk("t5_err_timeout", 64'(err_timeout), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        start_job();
        @(negedge clk);
        chk("t5_restart_busy", 64'(busy), 1);
        @(posedge clk); #1;
        send(10'd40, 1'b1);
        push_res(64'h77, 1'b1);
        wait_idle();
        chk("t5_job_done", 64'(jd_cnt), 5);

        // Simultaneous push/pop on a full FIFO for ten cycles keeps order, no overflow.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_res(64'(i), 1'b1);
        @(negedge clk);
        chk("t6_full_valid", 64'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        mac_push  = 1'b1;
        for (int i = 5; i <= 14; i++) begin
            mac_dout = 64'(i);
            exp_q.push_back(64'(i));
            @(posedge clk); #1;
        end
        mac_push = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_err_overflow", 64'(err_overflow), 0);
        chk("t6_out_count", 64'(exp_q.size()), 0);
        chk("mac_issue_left", 64'(exp_mac.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
